// File: rtl/nf_ahb2core.sv
// nf_ahb2core: AHB-Lite slave port re-issued as a native core request.
// Each selected NONSEQ/SEQ beat becomes one req/req_ack handshake on the core
// side. The bridge stalls HREADYOUT until the core acknowledges. Illegal or
// timed-out accesses get a two-cycle AHB ERROR response.
module nf_ahb2core #(
   parameter int unsigned ack_timeout = 256
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [31:0] haddr_s,
   input  logic [31:0] hwdata_s,
   output logic [31:0] hrdata_s,
   input  logic        hwrite_s,
   input  logic [1:0]  htrans_s,
   input  logic [2:0]  hsize_s,
   input  logic [2:0]  hburst_s,
   output logic [1:0]  hresp_s,
   output logic        hready_s,
   input  logic        hsel_s,
   output logic [31:0] addr,
   output logic [31:0] wd,
   output logic        we,
   output logic [1:0]  size,
   output logic        req,
   input  logic [31:0] rd,
   input  logic        req_ack
);

   typedef enum logic [1:0] {IDLE, REQ, ERR1, ERR2} state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   state_t      state_q;
   logic [31:0] hrdata_q;
   logic [31:0] addr_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        req_q;
   logic        hready_q;
   logic [1:0]  hresp_q;
   logic [15:0] cnt_q;

   logic [15:0] cnt_d;
   logic        valid_ap_d;
   logic        illegal_d;
   logic        timeout_d;

   // Every beat is treated as a single, so the burst type and the
   // NONSEQ/SEQ distinction carry no information here.
   logic unused_in;
   assign unused_in = ^{hburst_s, htrans_s[0]};

   assign hrdata_s = hrdata_q;
   assign addr     = addr_q;
   assign we       = we_q;
   assign size     = size_q;
   assign req      = req_q;
   assign hready_s = hready_q;
   assign hresp_s  = hresp_q;

   // Write data is passed straight through; the master holds HWDATA during wait states
   assign wd = hwdata_s;

   assign cnt_d      = cnt_q + 16'd1;
   assign valid_ap_d = hsel_s & htrans_s[1] & hready_q;
   assign timeout_d  = (ack_timeout != 0) && (32'(cnt_d) == 32'(ack_timeout));

   // Decode accesses the core cannot perform: oversize or misaligned
   always_comb begin
      illegal_d = 1'b0;
      if (hsize_s > 3'd2)
         illegal_d = 1'b1;
      else if (hsize_s == 3'd1 && haddr_s[0])
         illegal_d = 1'b1;
      else if (hsize_s == 3'd2 && haddr_s[1:0] != 2'b00)
         illegal_d = 1'b1;
   end

   // Bridge FSM with registered AHB and core-side outputs
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q  <= IDLE;
         hrdata_q <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         req_q    <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE, ERR2: begin
               if (valid_ap_d) begin
                  addr_q <= haddr_s;
                  we_q   <= hwrite_s;
                  size_q <= hsize_s[1:0];
                  cnt_q  <= '0;
                  hready_q <= 1'b0;
                  if (illegal_d) begin
                     state_q <= ERR1;
                     req_q   <= 1'b0;
                     hresp_q <= RESP_ERROR;
                  end else begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                     hresp_q <= RESP_OKAY;
                  end
               end else begin
                  state_q  <= IDLE;
                  req_q    <= 1'b0;
                  hready_q <= 1'b1;
                  hresp_q  <= RESP_OKAY;
               end
            end
            REQ: begin
               cnt_q <= cnt_d;
               // An ack in the final allowed cycle still completes normally
               if (req_ack) begin
                  if (!we_q)
                     hrdata_q <= rd;
                  state_q  <= IDLE;
                  req_q    <= 1'b0;
                  hready_q <= 1'b1;
                  hresp_q  <= RESP_OKAY;
               end else if (timeout_d) begin
                  state_q <= ERR1;
                  req_q   <= 1'b0;
                  hresp_q <= RESP_ERROR;
               end
            end
            ERR1: begin
               state_q  <= ERR2;
               hready_q <= 1'b1;
               hresp_q  <= RESP_ERROR;
            end
            default: begin
               state_q  <= IDLE;
               req_q    <= 1'b0;
               hready_q <= 1'b1;
               hresp_q  <= RESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nf_ahb2core.sv
// Directed bench for nf_ahb2core built with a short ack timeout of 4 cycles.
module tb_nf_ahb2core;

   logic        hclk = 1'b0;
   logic        hreset;
   logic [31:0] haddr_s, hwdata_s, hrdata_s;
   logic        hwrite_s;
   logic [1:0]  htrans_s;
   logic [2:0]  hsize_s, hburst_s;
   logic [1:0]  hresp_s;
   logic        hready_s, hsel_s;
   logic [31:0] addr, wd, rd;
   logic        we, req, req_ack;
   logic [1:0]  size;

   int n_chk = 0;
   int n_fail = 0;

   // Results of the most recent xfer() call
   int          n_req, n_wait;
   logic [31:0] o_addr, o_wd, o_rdata;
   logic        o_we;
   logic [1:0]  o_size, o_resp;

   nf_ahb2core #(.ack_timeout(4)) dut (
      .hclk(hclk), .hreset(hreset),
      .haddr_s(haddr_s), .hwdata_s(hwdata_s), .hrdata_s(hrdata_s),
      .hwrite_s(hwrite_s), .htrans_s(htrans_s), .hsize_s(hsize_s),
      .hburst_s(hburst_s), .hresp_s(hresp_s), .hready_s(hready_s),
      .hsel_s(hsel_s), .addr(addr), .wd(wd), .we(we), .size(size),
      .req(req), .rd(rd), .req_ack(req_ack)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // One AHB beat; the core acks on the (ack_dly+1)-th req cycle, never if ack_dly < 0
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wdat, input int ack_dly, input logic [31:0] rdat);
      int k;
      hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = a; hwrite_s = w; hsize_s = sz;
      tick();
      hsel_s = 1'b0; htrans_s = 2'b00; haddr_s = '0; hwdata_s = wdat;
      #1;
      n_req = 0; n_wait = 0; k = 0;
      o_addr = 'x; o_we = 'x; o_size = 'x; o_wd = 'x;
      while (hready_s == 1'b0 && k < 40) begin
         n_wait++;
         if (req) begin
            if (n_req == 0) begin
               o_addr = addr; o_we = we; o_size = size; o_wd = wd;
            end
            req_ack = (ack_dly >= 0) && (n_req == ack_dly);
            rd      = req_ack ? rdat : 32'hBAD0_BAD0;
            n_req++;
         end else begin
            req_ack = 1'b0;
         end
         tick();
         k++;
      end
      req_ack = 1'b0;
      rd      = 32'h5555_5555;
      o_resp  = hresp_s;
      o_rdata = hrdata_s;
      chk("xfer_done", {31'd0, hready_s}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got 0x00000001 expected 0x00000000");
      $fatal(1, "simulation time limit");
   end

   initial begin
      hreset = 1'b1; haddr_s = '0; hwdata_s = '0; hwrite_s = 1'b0; htrans_s = 2'b00;
      hsize_s = 3'd0; hburst_s = 3'd0; hsel_s = 1'b0; rd = '0; req_ack = 1'b0;
      repeat (2) tick();
      chk("rst_req",    {31'd0, req},      32'd0);
      chk("rst_hready", {31'd0, hready_s}, 32'd1);
      chk("rst_hresp",  {30'd0, hresp_s},  32'd0);
      chk("rst_hrdata", hrdata_s,          32'd0);
      chk("rst_addr",   addr,              32'd0);
      hreset = 1'b0;
      tick();

      // Word read, ack in first REQ cycle
      xfer(32'h10, 1'b0, 3'd2, 32'h0, 0, 32'hDEAD_BEEF);
      chk("rd_nreq",  n_req,  1);
      chk("rd_nwait", n_wait, 1);
      chk("rd_addr",  o_addr, 32'h10);
      chk("rd_we",    {31'd0, o_we},   32'd0);
      chk("rd_size",  {30'd0, o_size}, 32'd2);
      chk("rd_data",  o_rdata, 32'hDEAD_BEEF);
      chk("rd_resp",  {30'd0, o_resp}, 32'd0);

      // Byte write, ack three cycles late: ack in the final allowed cycle wins over timeout
      xfer(32'h13, 1'b1, 3'd0, 32'h0000_00A5, 3, 32'h9999_9999);
      chk("bw_nreq",  n_req,  4);
      chk("bw_nwait", n_wait, 4);
      chk("bw_addr",  o_addr, 32'h13);
      chk("bw_wd",    o_wd,   32'hA5);
      chk("bw_we",    {31'd0, o_we},   32'd1);
      chk("bw_size",  {30'd0, o_size}, 32'd0);
      chk("bw_resp",  {30'd0, o_resp}, 32'd0);
      chk("bw_hrdata_kept", o_rdata, 32'hDEAD_BEEF);

      // Back-to-back: write 0x4 then read 0x8 with no idle cycle between
      hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'h4; hwrite_s = 1'b1; hsize_s = 3'd2;
      tick();
      hsel_s = 1'b0; htrans_s = 2'b00; hwdata_s = 32'h1122_3344; req_ack = 1'b1; rd = 32'h7777_7777;
      #1;
      chk("b2b_req1",  {31'd0, req}, 32'd1);
      chk("b2b_addr1", addr, 32'h4);
      chk("b2b_wd1",   wd,   32'h1122_3344);
      tick();
      chk("b2b_done1", {31'd0, hready_s}, 32'd1);
      chk("b2b_req_off", {31'd0, req}, 32'd0);
      req_ack = 1'b0;
      hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'h8; hwrite_s = 1'b0; hsize_s = 3'd2;
      tick();
      chk("b2b_req2",  {31'd0, req}, 32'd1);
      chk("b2b_addr2", addr, 32'h8);
      chk("b2b_we2",   {31'd0, we}, 32'd0);
      hsel_s = 1'b0; htrans_s = 2'b00; req_ack = 1'b1; rd = 32'hCAFE_F00D;
      tick();
      req_ack = 1'b0;
      chk("b2b_done2", {31'd0, hready_s}, 32'd1);
      chk("b2b_data2", hrdata_s, 32'hCAFE_F00D);

      // Illegal: misaligned word, then hsize 3
      xfer(32'h2, 1'b0, 3'd2, 32'h0, 0, 32'h0);
      chk("mis_nreq",  n_req,  0);
      chk("mis_nwait", n_wait, 1);
      chk("mis_resp",  {30'd0, o_resp}, 32'd1);
      xfer(32'h0, 1'b0, 3'd3, 32'h0, 0, 32'h0);
      chk("sz3_nreq",  n_req,  0);
      chk("sz3_nwait", n_wait, 1);
      chk("sz3_resp",  {30'd0, o_resp}, 32'd1);

      // Timeout with no ack, then a normal transfer
      xfer(32'h20, 1'b0, 3'd2, 32'h0, -1, 32'h0);
      chk("to_nreq",  n_req,  4);
      chk("to_nwait", n_wait, 5);
      chk("to_resp",  {30'd0, o_resp}, 32'd1);
      chk("to_hrdata_kept", o_rdata, 32'hCAFE_F00D);
      xfer(32'h24, 1'b0, 3'd1, 32'h0, 1, 32'h1234_5678);
      chk("post_nreq", n_req, 2);
      chk("post_resp", {30'd0, o_resp}, 32'd0);
      chk("post_data", o_rdata, 32'h1234_5678);
      chk("post_size", {30'd0, o_size}, 32'd1);

      // Non-transfers and stray acks
      hsel_s = 1'b1; htrans_s = 2'b00; haddr_s = 32'h30; hsize_s = 3'd2;
      tick();
      chk("idle_req",    {31'd0, req},      32'd0);
      chk("idle_hready", {31'd0, hready_s}, 32'd1);
      htrans_s = 2'b01;
      tick();
      chk("busy_req",    {31'd0, req},      32'd0);
      chk("busy_hready", {31'd0, hready_s}, 32'd1);
      hsel_s = 1'b0; htrans_s = 2'b10;
      tick();
      chk("unsel_req",   {31'd0, req},      32'd0);
      htrans_s = 2'b00; req_ack = 1'b1; rd = 32'hFFFF_FFFF;
      tick();
      req_ack = 1'b0;
      chk("stray_ack_req",    {31'd0, req}, 32'd0);
      chk("stray_ack_hrdata", hrdata_s, 32'h1234_5678);

      // Asynchronous reset in the middle of REQ
      hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'h40; hwrite_s = 1'b1; hsize_s = 3'd2;
      tick();
      hsel_s = 1'b0; htrans_s = 2'b00;
      chk("mid_req_on", {31'd0, req}, 32'd1);
      #2 hreset = 1'b1;
      #1;
      chk("arst_req",    {31'd0, req},      32'd0);
      chk("arst_hready", {31'd0, hready_s}, 32'd1);
      chk("arst_hresp",  {30'd0, hresp_s},  32'd0);
      chk("arst_hrdata", hrdata_s,          32'd0);
      chk("arst_addr",   addr,              32'd0);
      chk("arst_we",     {31'd0, we},       32'd0);
      tick();
      hreset = 1'b0;
      tick();
      chk("after_rst_req", {31'd0, req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
